spram_be: RTL and testbench

Parametrised single-port synchronous RAM for core-side work memories (scratch RAM, line buffers, CPU work RAM). Adds to the basic single-port RAM: per-byte write enables, a selectable read-during-write mode, an optional output register stage, a read-valid strobe, and a hardware clear engine that fills the whole array with a constant after reset or on request. It sits between core logic and inferred block RAM; while a clear runs, the block owns the array and ignores the user port.

---
 rtl/spram_be.sv | 144 ++++++++++++++
 tb/tb_spram_be.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spram_be.sv
// spram_be: single-port synchronous RAM with per-lane write enables,
// selectable read-during-write result, optional output register, read-valid
// strobe and a clear engine that fills the array after reset or on request.
//
// Handshake: there is no backpressure. A read is accepted on a rising edge
// where rden=1 and the clear engine is idle. Its data appears on q with
// q_valid=1 for exactly one cycle, either 1 or 2 cycles later depending on
// out_reg. A write is performed on a rising edge where wren=1 and the engine
// is idle. While busy=1 the user port (rden, wren, clear) is ignored.
module spram_be #(
  parameter int address_width = 10,
  parameter int data_width = 8,
  parameter int byte_width = 8,
  parameter int rdw_mode = 0,
  parameter int out_reg = 0,
  parameter logic [data_width-1:0] clear_value = '0,
  localparam int lanes = (data_width + byte_width - 1) / byte_width
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     rden,
  input  logic                     wren,
  input  logic [lanes-1:0]         byteena,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    data,
  output logic [data_width-1:0]    q,
  output logic                     q_valid,
  output logic                     fsm_state
);

  localparam int depth = 1 << address_width;

  typedef enum logic {
    st_idle  = 1'b0,
    st_clear = 1'b1
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [address_width-1:0] clr_cnt;
  logic [data_width-1:0]    mem [depth];

  logic [data_width-1:0]    lane_mask;
  logic [data_width-1:0]    old_word;
  logic [data_width-1:0]    merged_word;
  logic [data_width-1:0]    rd_word;
  logic [data_width-1:0]    wr_mask;
  logic [data_width-1:0]    wr_word;
  logic [address_width-1:0] wr_addr;
  logic                     rd_accept;

  logic [data_width-1:0]    stage1_data;
  logic                     stage1_valid;
  logic [data_width-1:0]    stage2_data;
  logic                     stage2_valid;

  // Spread each lane enable over the bits it covers; the top lane naturally
  // covers only the leftover bits when data_width is not a lane multiple.
  genvar g;
  for (g = 0; g < data_width; g++) begin : g_lane_mask
    assign lane_mask[g] = byteena[g / byte_width];
  end

  // FSM state register; reset always restarts a full clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= st_clear;
    else       state_q <= state_d;
  end

  // FSM next state and busy flag; the last clear write happens when the
  // counter is all ones, after which the user port is released.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      st_clear: begin
        busy = 1'b1;
        if (&clr_cnt) state_d = st_idle;
      end
      default: begin
        if (clear) state_d = st_clear;
      end
    endcase
  end

  // Clear address counter; wraps back to 0 on the final clear write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     clr_cnt <= '0;
    else if (busy) clr_cnt <= clr_cnt + 1'b1;
  end

  // Port steering: the clear engine owns the write port while busy, and the
  // read-during-write result is either the stored word or the merged word.
  always_comb begin
    old_word    = mem[address];
    merged_word = (old_word & ~lane_mask) | (data & lane_mask);
    rd_word     = ((rdw_mode != 0) && wren) ? merged_word : old_word;
    rd_accept   = !busy && rden;
    if (busy) begin
      wr_addr = clr_cnt;
      wr_word = clear_value;
      wr_mask = '1;
    end else begin
      wr_addr = address;
      wr_word = data;
      wr_mask = wren ? lane_mask : '0;
    end
  end

  // Array write with bit mask; a write with no lanes enabled does nothing.
  always_ff @(posedge clock) begin
    if (|wr_mask) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_word & wr_mask);
  end

  // First read stage; data holds between accepted reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage1_data  <= '0;
      stage1_valid <= 1'b0;
    end else begin
      stage1_valid <= rd_accept;
      if (rd_accept) stage1_data <= rd_word;
    end
  end

  // Optional output register stage; reads already in flight drain even if
  // a clear starts behind them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage2_data  <= '0;
      stage2_valid <= 1'b0;
    end else begin
      stage2_valid <= stage1_valid;
      if (stage1_valid) stage2_data <= stage1_data;
    end
  end

  assign q         = (out_reg != 0) ? stage2_data  : stage1_data;
  assign q_valid   = (out_reg != 0) ? stage2_valid : stage1_valid;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spram_be.sv
// Directed bench for spram_be: three instances share one input port
// (old-data read-during-write, new-data read-during-write, registered output)
// and each step checks the outputs against hand-computed values.
module tb_spram_be;

  localparam int aw = 4;
  localparam int dw = 16;
  localparam int bw = 8;
  localparam logic [dw-1:0] cv = 16'hA5A5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          rden = 1'b0;
  logic          wren = 1'b0;
  logic [1:0]    byteena = 2'b00;
  logic [aw-1:0] address = '0;
  logic [dw-1:0] data = '0;

  logic          busy_old, busy_new, busy_reg;
  logic [dw-1:0] q_old, q_new, q_reg;
  logic          v_old, v_new, v_reg;
  logic          st_old, st_new, st_reg;

  int total = 0;
  int bad = 0;
  int n_busy;
  int n_vseen;

  // Clock: 10 time-unit period; inputs change and outputs are sampled on
  // the falling edge.
  always #5 clock = ~clock;

  spram_be #(.address_width(aw), .data_width(dw), .byte_width(bw),
             .rdw_mode(0), .out_reg(0), .clear_value(cv)) u_old (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy_old),
    .rden(rden), .wren(wren), .byteena(byteena), .address(address),
    .data(data), .q(q_old), .q_valid(v_old), .fsm_state(st_old));

  spram_be #(.address_width(aw), .data_width(dw), .byte_width(bw),
             .rdw_mode(1), .out_reg(0), .clear_value(cv)) u_new (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy_new),
    .rden(rden), .wren(wren), .byteena(byteena), .address(address),
    .data(data), .q(q_new), .q_valid(v_new), .fsm_state(st_new));

  spram_be #(.address_width(aw), .data_width(dw), .byte_width(bw),
             .rdw_mode(0), .out_reg(1), .clear_value(cv)) u_reg (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy_reg),
    .rden(rden), .wren(wren), .byteena(byteena), .address(address),
    .data(data), .q(q_reg), .q_valid(v_reg), .fsm_state(st_reg));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] be,
                       input logic [aw-1:0] addr, input logic [dw-1:0] d);
    rden = rd;
    wren = wr;
    byteena = be;
    address = addr;
    data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  // Counts falling edges with busy high (bounded), noting any q_valid seen.
  task automatic count_busy(output int n, output int vseen);
    n = 0;
    vseen = 0;
    while (busy_old && n < 100) begin
      n++;
      if (v_old || v_reg) vseen++;
      @(negedge clock);
    end
  endtask

  // Back-to-back reads of every address on the out_reg=0 instance.
  task automatic sweep(input string tag, input logic [dw-1:0] exp);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        check($sformatf("%s_valid_%0d", tag, i - 1), {31'd0, v_old}, 32'd1);
        check($sformatf("%s_data_%0d", tag, i - 1), {16'd0, q_old}, {16'd0, exp});
      end
      if (i < 16) drive(1'b1, 1'b0, 2'b00, aw'(i), '0);
      else        idle();
      @(negedge clock);
    end
  endtask

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy_old}, 32'd1);
    check("rst_state", {31'd0, st_old}, 32'd1);
    check("rst_q", {16'd0, q_old}, 32'd0);
    check("rst_qv", {31'd0, v_old}, 32'd0);
    check("rst_q_reg", {16'd0, q_reg}, 32'd0);

    // ---- power-up clear: 16 busy cycles, then every word reads clear_value ----
    reset = 1'b0;
    count_busy(n_busy, n_vseen);
    check("init_busy_cycles", n_busy, 32'd16);
    check("init_state_idle", {31'd0, st_old}, 32'd0);
    sweep("init", cv);

    // ---- byte enables ----
    drive(1'b0, 1'b1, 2'b11, 4'd3, 16'h1234); @(negedge clock);
    drive(1'b0, 1'b1, 2'b01, 4'd3, 16'hFF00); @(negedge clock);
    drive(1'b0, 1'b1, 2'b00, 4'd4, 16'hFFFF); @(negedge clock);
    drive(1'b1, 1'b0, 2'b00, 4'd3, '0);       @(negedge clock);
    check("be_low_lane_v", {31'd0, v_old}, 32'd1);
    check("be_low_lane", {16'd0, q_old}, 32'h1200);
    drive(1'b1, 1'b0, 2'b00, 4'd4, '0);       @(negedge clock);
    check("be_none", {16'd0, q_old}, {16'd0, cv});
    idle();                                   @(negedge clock);
    check("hold_qv", {31'd0, v_old}, 32'd0);
    check("hold_q", {16'd0, q_old}, {16'd0, cv});

    // ---- read during write ----
    drive(1'b0, 1'b1, 2'b11, 4'd5, 16'h0F0F); @(negedge clock);
    drive(1'b1, 1'b1, 2'b10, 4'd5, 16'hBEEF); @(negedge clock);
    check("rdw_old", {16'd0, q_old}, 32'h0F0F);
    check("rdw_new", {16'd0, q_new}, 32'hBE0F);
    check("rdw_new_v", {31'd0, v_new}, 32'd1);
    drive(1'b1, 1'b0, 2'b00, 4'd5, '0);       @(negedge clock);
    check("rdw_after_old", {16'd0, q_old}, 32'hBE0F);
    check("rdw_after_new", {16'd0, q_new}, 32'hBE0F);

    // ---- output register: three back-to-back reads ----
    drive(1'b0, 1'b1, 2'b11, 4'd0, 16'h1111); @(negedge clock);
    drive(1'b0, 1'b1, 2'b11, 4'd1, 16'h2222); @(negedge clock);
    drive(1'b0, 1'b1, 2'b11, 4'd2, 16'h3333); @(negedge clock);
    idle();                                   @(negedge clock);
    check("oreg_pre_v", {31'd0, v_reg}, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0, '0);       @(negedge clock);
    check("oreg_lat1_v", {31'd0, v_reg}, 32'd0);
    check("oreg_ref_out0", {16'd0, q_old}, 32'h1111);
    drive(1'b1, 1'b0, 2'b00, 4'd1, '0);       @(negedge clock);
    check("oreg_v0", {31'd0, v_reg}, 32'd1);
    check("oreg_d0", {16'd0, q_reg}, 32'h1111);
    drive(1'b1, 1'b0, 2'b00, 4'd2, '0);       @(negedge clock);
    check("oreg_v1", {31'd0, v_reg}, 32'd1);
    check("oreg_d1", {16'd0, q_reg}, 32'h2222);
    idle();                                   @(negedge clock);
    check("oreg_v2", {31'd0, v_reg}, 32'd1);
    check("oreg_d2", {16'd0, q_reg}, 32'h3333);
    @(negedge clock);
    check("oreg_end_v", {31'd0, v_reg}, 32'd0);
    check("oreg_hold", {16'd0, q_reg}, 32'h3333);

    // ---- requested clear with user traffic during busy ----
    drive(1'b0, 1'b1, 2'b11, 4'd7, 16'h0000);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_busy_rise", {31'd0, busy_old}, 32'd1);
    drive(1'b1, 1'b1, 2'b11, 4'd9, 16'hDEAD);
    count_busy(n_busy, n_vseen);
    idle();
    check("clr_busy_cycles", n_busy, 32'd16);
    check("clr_no_qv_busy", n_vseen, 32'd0);
    check("clr_q_held", {16'd0, q_old}, 32'h3333);
    sweep("clr", cv);

    // ---- reset in the middle of a clear ----
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (7) @(negedge clock);
    check("mid_busy", {31'd0, busy_old}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_q", {16'd0, q_old}, 32'd0);
    check("mid_rst_qv", {31'd0, v_old}, 32'd0);
    check("mid_rst_q_reg", {16'd0, q_reg}, 32'd0);
    reset = 1'b0;
    count_busy(n_busy, n_vseen);
    check("mid_busy_cycles", n_busy, 32'd16);
    drive(1'b1, 1'b0, 2'b00, 4'd15, '0);      @(negedge clock);
    idle();
    check("mid_read_v", {31'd0, v_old}, 32'd1);
    check("mid_read", {16'd0, q_old}, {16'd0, cv});
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
